// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 memory controller slice:
// controller states, read-response beat layout and response-stage sizing.
package mpmc11_pkg;

   localparam int unsigned MPMC11_DATA_WIDTH = 128;
   localparam int unsigned MPMC11_CH_WIDTH   = 4;
   localparam int unsigned MPMC11_IDX_WIDTH  = 6;
   localparam int unsigned MPMC11_RESP_DEPTH = 16;

   typedef enum logic [3:0] {
      IDLE,
      ACTIVATE,
      READ_CMD,
      READ_DATA0,
      READ_DATA,
      WRITE_CMD,
      WRITE_DATA,
      PRECHARGE,
      REFRESH
   } mpmc11_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_CAPTURE,
      R_DRAIN
   } mpmc11_resp_state_t;

   typedef struct packed {
      logic [MPMC11_CH_WIDTH-1:0]   ch;
      logic [MPMC11_IDX_WIDTH-1:0]  idx;
      logic                         first;
      logic                         last;
      logic [MPMC11_DATA_WIDTH-1:0] data;
   } mpmc11_resp_beat_t;

endpackage

// File: rtl/mpmc11_resp_collect_if.sv
// Read-response return channel: tagged beats handed to the channel return mux
// over a valid/ready handshake.
interface mpmc11_resp_collect_if;
   import mpmc11_pkg::*;

   logic              resp_valid;
   logic              resp_ready;
   mpmc11_resp_beat_t resp_beat;

   modport master (output resp_valid, output resp_beat, input resp_ready);
   modport slave  (input resp_valid, input resp_beat, output resp_ready);

endinterface

// File: rtl/mpmc11_resp_fifo.sv
// Synchronous FIFO with occupancy, first-word fall-through read from the
// registered array, and drop-on-full push with a sticky overflow flag.
module mpmc11_resp_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level,
   output logic             overflow
);

   localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit lets wr_ptr - rd_ptr span 0..DEPTH without ambiguity.
   assign level    = wr_ptr - rd_ptr;
   assign empty    = (level == '0);
   assign full     = (level == FULL_LEVEL);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mpmc11_resp_collect.sv
// Read-response capture: tags each memory read beat with channel, index and
// first/last markers, and buffers it for the channel return mux.
module mpmc11_resp_collect
   import mpmc11_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MPMC11_DATA_WIDTH,
   parameter int unsigned DEPTH      = MPMC11_RESP_DEPTH,
   parameter int unsigned CH_WIDTH   = MPMC11_CH_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  mpmc11_state_t              state,
   input  logic                       rd_valid,
   input  logic [DATA_WIDTH-1:0]      rd_data,
   input  logic [5:0]                 burst_len,
   input  logic [CH_WIDTH-1:0]        req_ch,
   mpmc11_resp_collect_if.master      resp,
   output logic                       busy,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     level
);

   mpmc11_resp_state_t fsm;
   logic [CH_WIDTH-1:0] ch_q;
   logic [5:0]          len_q;
   logic [5:0]          idx_q;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   mpmc11_resp_beat_t   beat_in;
   mpmc11_resp_beat_t   beat_out;

   assign push = (fsm == R_CAPTURE) && rd_valid;
   assign pop  = resp.resp_valid && resp.resp_ready;
   assign busy = (fsm != R_IDLE);

   always_comb begin
      beat_in       = '0;
      beat_in.ch    = ch_q;
      beat_in.idx   = idx_q;
      beat_in.first = (idx_q == '0);
      beat_in.last  = (idx_q == len_q);
      beat_in.data  = rd_data;
   end

   // An abort (controller back to IDLE) overrides the capture decision but
   // the beat arriving in that same cycle is still pushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm   <= R_IDLE;
         ch_q  <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else begin
         case (fsm)
            R_IDLE: begin
               if (state == READ_DATA0) begin
                  ch_q  <= req_ch;
                  len_q <= burst_len;
                  idx_q <= '0;
                  fsm   <= R_CAPTURE;
               end
            end
            R_CAPTURE: begin
               if (rd_valid) begin
                  if (idx_q == len_q) fsm <= R_DRAIN;
                  else                idx_q <= idx_q + 6'd1;
               end
               if (state == IDLE) fsm <= R_DRAIN;
            end
            R_DRAIN: begin
               if (level == '0) fsm <= R_IDLE;
            end
            default: fsm <= R_IDLE;
         endcase
      end
   end

   mpmc11_resp_fifo #(
      .WIDTH ($bits(mpmc11_resp_beat_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (beat_in),
      .pop       (pop),
      .pop_data  (beat_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level),
      .overflow  (overflow)
   );

   assign resp.resp_valid = !fifo_empty;
   assign resp.resp_beat  = beat_out;

endmodule
